// File: rtl/mem_loader_pkg.sv
// Shared definitions for the serial memory loader.
// Holds the default memory depth (M) and word width (N), the address-width
// helper derived from the depth, and the loader state encoding.
package mem_loader_pkg;

    localparam int M_DEFAULT = 162;
    localparam int N_DEFAULT = 8;

    // Address width for a memory of 'depth' words; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int ADDR_W_DEFAULT = addr_width(M_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Bundle of the serial input pins and the memory write / status outputs of
// the loader.
//   cs_n, sclk, mosi        : serial frame select, bit clock, data (MSB first)
//   addr, data_out          : memory write address and data
//   write_enable            : one-cycle write strobe
//   busy, done, overflow    : loader status
// Modports: master = serial source / memory side, slave = the loader.
interface mem_loader_if #(
    parameter int M = mem_loader_pkg::M_DEFAULT,
    parameter int N = mem_loader_pkg::N_DEFAULT
) ();
    import mem_loader_pkg::*;

    localparam int AW = addr_width(M);

    logic          cs_n;
    logic          sclk;
    logic          mosi;
    logic [AW-1:0] addr;
    logic [N-1:0]  data_out;
    logic          write_enable;
    logic          busy;
    logic          done;
    logic          overflow;

    modport master (
        output cs_n, sclk, mosi,
        input  addr, data_out, write_enable, busy, done, overflow
    );

    modport slave (
        input  cs_n, sclk, mosi,
        output addr, data_out, write_enable, busy, done, overflow
    );

endinterface

// File: rtl/mem_loader_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
//   clk, reset : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   changed    : one-cycle pulse when the synchronized level changes;
//                the new level in q tells rise (q=1) from fall (q=0)
module sync_edge #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic changed
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= IDLE_VAL;
            s2 <= IDLE_VAL;
            s3 <= IDLE_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q       = s2;
    assign changed = s2 ^ s3;

endmodule

// File: rtl/mem_loader.sv
// Serial memory loader: receives N-bit words MSB first over a cs_n/sclk/mosi
// link and writes them to consecutive addresses 0..M-1 of a memory.
//   clk, reset : system clock, async active-low reset
//   bus        : mem_loader_if slave (serial inputs, write port, status)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no frame open; waiting for cs_n falling edge
// SHIFT | frame open, assembling the current word bit by bit
// WRITE | one-cycle write of the assembled word
// FULL  | M words written; further sclk edges only flag overflow
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.slave  bus
);

    localparam int AW = addr_width(M);
    localparam int CW = addr_width(N);
    localparam logic [AW-1:0] ADDR_LAST = AW'(M - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);

    logic cs_q, cs_chg, sclk_q, sclk_chg;
    logic cs_rise, cs_fall, sclk_rise;
    logic mosi_s1, mosi_s2;

    sync_edge #(.IDLE_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset   (reset),
        .d       (bus.cs_n),
        .q       (cs_q),
        .changed (cs_chg)
    );

    sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .d       (bus.sclk),
        .q       (sclk_q),
        .changed (sclk_chg)
    );

    // mosi only needs the level; its two flops keep it aligned with the
    // synchronized sclk so the sampled bit is the one present at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign cs_rise   = cs_chg & cs_q;
    assign cs_fall   = cs_chg & ~cs_q;
    assign sclk_rise = sclk_chg & sclk_q;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  shreg, word_nxt, data_q;
    logic          done_q, overflow_q;
    logic          write_enable, busy;

    assign word_nxt = {shreg[N-2:0], mosi_s2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        write_enable = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                // cs_n release wins over a simultaneous last-bit edge
                if (cs_rise)
                    state_nxt = ST_IDLE;
                else if (sclk_rise && bit_cnt == BIT_LAST)
                    state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy         = 1'b1;
                write_enable = 1'b1;
                if (cs_rise)
                    state_nxt = ST_IDLE;
                else if (addr_q == ADDR_LAST)
                    state_nxt = ST_FULL;
                else
                    state_nxt = ST_SHIFT;
            end
            ST_FULL: begin
                if (cs_rise) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        addr_q     <= '0;
                        bit_cnt    <= '0;
                        shreg      <= '0;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!cs_rise && sclk_rise) begin
                        shreg   <= word_nxt;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == BIT_LAST) data_q <= word_nxt;
                    end
                end
                ST_WRITE: begin
                    bit_cnt <= '0;
                    if (addr_q == ADDR_LAST) done_q <= 1'b1;
                    else                     addr_q <= addr_q + AW'(1);
                end
                ST_FULL: begin
                    if (sclk_rise) overflow_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.addr         = addr_q;
    assign bus.data_out     = data_q;
    assign bus.write_enable = write_enable;
    assign bus.busy         = busy;
    assign bus.done         = done_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

    localparam int M = 4;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mem_loader_if #(.M(M), .N(N)) bus ();

    mem_loader #(.M(M), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // reference model: words completed in this frame, bits of current word
    logic [15:0] sb_q[$];
    int          wc = 0;
    int          bits = 0;
    logic [7:0]  cur = '0;
    logic [7:0]  last_data = '0;
    bit          ovf_m = 1'b0;
    bit          open_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one sclk rising edge as seen by the specification rules
    task automatic model_bit(input bit b);
        if (wc >= M) begin
            ovf_m = 1'b1;
        end else begin
            cur = {cur[6:0], b};
            bits++;
            if (bits == N) begin
                sb_q.push_back({8'(wc), cur});
                last_data = cur;
                wc++;
                bits = 0;
            end
        end
    endtask

    task automatic send_bit(input bit b);
        bus.mosi = b;
        tick($urandom_range(5, 3));
        model_bit(b);
        bus.sclk = 1'b1;
        tick($urandom_range(5, 3));
        bus.sclk = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[N-1-i]);
    endtask

    task automatic frame_start();
        bus.cs_n = 1'b0;
        wc = 0; bits = 0; cur = '0; ovf_m = 1'b0; open_m = 1'b1;
        tick(4);
    endtask

    task automatic frame_end();
        tick(3);
        bus.cs_n = 1'b1;
        open_m = 1'b0; bits = 0;
        tick(4);
    endtask

    task automatic check_status(input string tag);
        tick(2);
        check({tag, "_busy"}, bus.busy, 32'(open_m && wc < M));
        check({tag, "_done"}, bus.done, 32'(wc == M));
        check({tag, "_overflow"}, bus.overflow, 32'(ovf_m));
        check({tag, "_addr"}, bus.addr, 32'((wc < M) ? wc : M - 1));
        check({tag, "_data"}, bus.data_out, 32'(last_data));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bus.addr, bus.data_out, bus.write_enable, bus.busy, bus.done, bus.overflow}, 32'h0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset === 1'b1 && bus.write_enable === 1'b1) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write", bus.addr, bus.data_out);
            end else begin
                e = sb_q.pop_front();
                check("write_addr", bus.addr, 32'(e[15:8]));
                check("write_data", bus.data_out, 32'(e[7:0]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int nw, tail;

        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        tick(3);
        check_all_zero("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_all_zero("reset_idle");
        end
        tick(1);

        // single word 0xA5 with exact write latency
        frame_start();
        send_word(8'hA5, 7);
        bus.mosi = 1'b1;
        tick(3);
        model_bit(1'b1);
        bus.sclk = 1'b1;
        repeat (3) @(negedge clk);
        check("we_early", bus.write_enable, 32'h0);
        @(negedge clk);
        check("we_latency", bus.write_enable, 32'h1);
        check("we_busy", bus.busy, 32'h1);
        check("we_done", bus.done, 32'h0);
        @(negedge clk);
        check("we_width", bus.write_enable, 32'h0);
        tick(1);
        bus.sclk = 1'b0;
        check_status("a5");
        frame_end();
        check_status("a5_end");

        // four words fill the memory, then overflow
        frame_start();
        for (int i = 1; i <= 4; i++) begin
            send_word(8'(i), 8);
            check_status("fill");
        end
        send_word(8'hFF, 3);
        check_status("ovf");
        frame_end();
        check_status("ovf_held");
        frame_start();
        check_status("ovf_cleared");
        frame_end();

        // abort after 5 bits of word 1, then restart from address 0
        frame_start();
        send_word(8'($urandom), 8);
        send_word(8'($urandom), 5);
        frame_end();
        check_status("abort");
        frame_start();
        send_word(8'h3C, 8);
        frame_end();
        check_status("restart");

        // cs_n release detected together with the last bit: discarded
        frame_start();
        send_word(8'h81, 7);
        bus.mosi = 1'b1;
        tick(3);
        bus.sclk = 1'b1;
        bus.cs_n = 1'b1;
        open_m = 1'b0; bits = 0;
        tick(4);
        bus.sclk = 1'b0;
        tick(4);
        check_status("cs_wins");

        // cs_n release detected while writing: write completes
        frame_start();
        send_word(8'h5A, 7);
        bus.mosi = 1'b0;
        tick(3);
        model_bit(1'b0);
        bus.sclk = 1'b1;
        tick(1);
        bus.cs_n = 1'b1;
        open_m = 1'b0; bits = 0;
        tick(4);
        bus.sclk = 1'b0;
        tick(4);
        check_status("cs_in_write");

        // reset mid-frame
        frame_start();
        send_word(8'($urandom), 7);
        tick(1);
        reset = 1'b0;
        bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        wc = 0; bits = 0; ovf_m = 1'b0; open_m = 1'b0; last_data = '0;
        tick(2);
        check_all_zero("rst_mid");
        reset = 1'b1;
        tick(3);
        check_all_zero("rst_after");
        frame_start();
        for (int i = 0; i < 4; i++) send_word(8'($urandom), 8);
        check_status("rst_reload");
        frame_end();

        // randomized frames
        for (int f = 0; f < 15; f++) begin
            frame_start();
            check_status("rnd_start");
            nw = $urandom_range(6, 0);
            for (int i = 0; i < nw; i++) begin
                w = 8'($urandom);
                send_word(w, 8);
                check_status("rnd_word");
            end
            tail = $urandom_range(7, 0);
            send_word(8'($urandom), tail);
            frame_end();
            check_status("rnd_end");
        end

        tick(10);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter M, default 162, number of memory words to load.
REQ-002 Parameter N, default 8, word width in bits.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cs_n  input  1  serial frame select, active-low, asynchronous to clk.
REQ-006 sclk  input  1  serial bit clock, asynchronous to clk.
REQ-007 mosi  input  1  serial data, MSB of each word first.
REQ-008 addr  output  $clog2(M)  write address to the weight/delay memory.
REQ-009 data_out  output  N  write data to the memory data_in port.
REQ-010 write_enable  output  1  one-cycle write strobe.
REQ-011 busy  output  1  high while a frame is open and fewer than M words are written.
REQ-012 done  output  1  high once M words are written in the current or last frame.
REQ-013 overflow  output  1  sticky: sclk edge received after M words in a frame.

Function
REQ-014 cs_n, sclk and mosi SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized values with one additional flop.
REQ-015 Legal timing: sclk high and low phases, and cs_n setup before the first sclk rise, each at least 3 clk periods.
REQ-016 State machine states: IDLE, SHIFT, WRITE, FULL.
REQ-017 IDLE -> SHIFT on synchronized cs_n falling edge; addr, bit counter cleared to 0; done and overflow cleared.
REQ-018 In SHIFT, each synchronized sclk rising edge SHALL shift synchronized mosi into the LSB of an N-bit shift register and increment the bit counter.
REQ-019 On the edge completing bit N-1, SHIFT -> WRITE; in WRITE, data_out holds the assembled word, write_enable=1 for exactly one cycle, addr unchanged.
REQ-020 Latency: write_enable SHALL assert in the clk cycle after the cycle in which the last-bit sclk edge is detected.
REQ-021 WRITE -> SHIFT with addr+1 and bit counter 0 if addr < M-1; otherwise WRITE -> FULL with done=1, addr held at M-1.
REQ-022 In FULL, sclk edges SHALL NOT write; any sclk rising edge sets overflow=1.
REQ-023 Synchronized cs_n rising edge in SHIFT or FULL SHALL return to IDLE; a partial word SHALL be discarded with no write.
REQ-024 cs_n rising edge detected in the same cycle as a last-bit sclk edge: cs_n wins, word discarded, no write.
REQ-025 cs_n rising edge while in WRITE: the write completes, then the state goes to IDLE.
REQ-026 done and overflow SHALL hold their values in IDLE until the next frame start.
REQ-027 write_enable SHALL be 0 in every state except WRITE; addr SHALL never exceed M-1.
REQ-028 data_out SHALL hold the last written word between writes.
REQ-029 busy = 1 exactly in SHIFT and WRITE.

Reset
REQ-030 While reset=0: state IDLE, addr=0, data_out=0, write_enable=0, busy=0, done=0, overflow=0, shift register and bit counter 0, synchronizers at idle levels (cs_n=1, sclk=0, mosi=0).
REQ-031 Reset asserted mid-frame SHALL abort with no write; after release, the block waits for a fresh cs_n falling edge.

Structure
REQ-032 The shared SNN package SHALL hold the default M and N and the state encoding; the address width SHALL be derived there as $clog2(M).
REQ-033 One sub-module, sync_edge (2-flop synchronizer plus rise/fall detect), SHALL be instantiated for cs_n and sclk; mosi uses its synchronizer without edge outputs.

Verification
REQ-034 Reset low, then high with idle inputs -> all outputs 0 for 20 cycles.
REQ-035 Frame with word 0xA5 (M=4, N=8) -> one write_enable pulse, addr=0, data_out=0xA5, busy=1, done=0.
REQ-036 Frame of 4 words 0x01,0x02,0x03,0x04 (M=4) -> writes at addr 0..3 in order, done=1 after the 4th, addr=3.
REQ-037 After 4 words, 3 more sclk pulses -> no write, overflow=1; next cs_n fall clears done and overflow.
REQ-038 cs_n raised after 5 bits of word 1 -> no write, IDLE; new frame restarts at addr=0.
REQ-039 reset pulsed low after bit 7 of word 0 -> no write, all outputs 0; the next frame loads correctly from addr=0.
